// File: rtl/cla_pkg.sv
// Shared definitions for the multi-cycle wide adder/subtractor.
//   state_e : FSM encoding (S_IDLE, S_RUN, S_DONE)
//   WORD_W  : width of one adder pass
//   CNT_W() : width of the pass counter for a given word count
package cla_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    localparam int WORD_W = 16;

    // One extra bit so the counter can never wrap while stepping through NWORDS passes.
    function automatic int CNT_W(input int nwords);
        return $clog2(nwords) + 1;
    endfunction

endpackage

// File: rtl/cla_wide_add_seq_cla16.sv
// 16-bit two-level carry-lookahead adder (four 4-bit lookahead groups).
// Ports:
//   a_i, b_i  : 16-bit operands
//   c_i       : carry in
//   sum_o     : 16-bit sum
//   c_o       : carry out of bit 15
//   p_grp_o   : block propagate (all 16 bits propagate)
//   g_grp_o   : block generate (carry produced independent of c_i)
module CLA_16_bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        c_i,
    output logic [15:0] sum_o,
    output logic        c_o,
    output logic        p_grp_o,
    output logic        g_grp_o
);

    logic [15:0] g;
    logic [15:0] p;
    logic [16:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  cg;

    always_comb begin
        g  = a_i & b_i;
        p  = a_i ^ b_i;
        gg = '0;
        gp = '0;
        cg = '0;
        c  = '0;

        // Group generate/propagate, flattened so each group is a single lookahead level.
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end

        // Second-level lookahead across groups.
        cg[0] = c_i;
        cg[1] = gg[0] | (gp[0] & c_i);
        cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_i);
        cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & c_i);
        cg[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & c_i);

        // Bit carries inside each group, seeded by the group carry-in.
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = cg[k];
            c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
        end
        c[16] = cg[4];
    end

    assign sum_o   = p ^ c[15:0];
    assign c_o     = c[16];
    assign p_grp_o = &gp;
    assign g_grp_o = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                   | (gp[3] & gp[2] & gp[1] & gg[0]);

endmodule

// File: rtl/cla_wide_add_seq.sv
// Multi-cycle wide adder/subtractor. A single 16-bit CLA is reused NWORDS times,
// least-significant word first, with the inter-word carry held in a flop.
// Optional feature macro: CLA_SEQ_OVF_EN adds the signed-overflow output ovf.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake (ready only in IDLE)
//   a, b, c_in, sub     : operands, carry-in (add only), 1 = subtract a-b
//   out_valid/out_ready : result handshake (valid only in DONE)
//   sum, c_out          : W-bit result mod 2^W, carry out (sub: 1 = no borrow)
//   ovf                 : signed overflow (CLA_SEQ_OVF_EN only)
module cla_wide_add_seq
    import cla_pkg::*;
#(
    parameter  int NWORDS = 4,
    localparam int W      = WORD_W * NWORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         c_out
`ifdef CLA_SEQ_OVF_EN
    ,output logic        ovf
`endif
);

    localparam int CW = CNT_W(NWORDS);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  res_q, res_d;

    logic [WORD_W-1:0] add_sum;
    logic              add_cout;

    CLA_16_bit u_cla (
        .a_i     (a_q[WORD_W-1:0]),
        .b_i     (b_q[WORD_W-1:0]),
        .c_i     (carry_q),
        .sum_o   (add_sum),
        .c_o     (add_cout),
        .p_grp_o (),
        .g_grp_o ()
    );

`ifdef CLA_SEQ_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
`ifdef CLA_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    // Subtraction is a + ~b + 1, so the +1 enters as the initial carry.
                    carry_d = sub ? 1'b1 : c_in;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> WORD_W;
                b_d     = b_q >> WORD_W;
                // Result fills from the top so the first (LS) word ends at bit 0 after NWORDS shifts.
                res_d   = {add_sum, res_q[W-1:WORD_W]};
                carry_d = add_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NWORDS - 1)) begin
                    state_d = S_DONE;
`ifdef CLA_SEQ_OVF_EN
                    // On the last pass word 0 of the shift registers holds the operand sign bits.
                    ovf_d = ~(a_q[WORD_W-1] ^ b_q[WORD_W-1]) & (add_sum[WORD_W-1] ^ a_q[WORD_W-1]);
`endif
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
`ifdef CLA_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
`ifdef CLA_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign sum       = res_q;
    // After the last pass the carry flop holds the carry out of bit W-1 and is frozen in DONE.
    assign c_out     = carry_q;
`ifdef CLA_SEQ_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule
